// File: rtl/ps2_scancode_decoder.sv
// PS/2 keyboard receiver: filters the raw lines, deserialises 11-bit frames, strips E0/F0/E1 prefixes.
// One registered event per make/break, 1 clk after the stop-bit edge; no backpressure (strobe outputs).
module ps2_scancode_decoder #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 65535
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2clk_in,
   input  logic       ps2data_in,
   output logic       scan_received,
   output logic [7:0] scancode,
   output logic       extended,
   output logic       released,
   output logic       parity_error,
   output logic       frame_timeout
);

   localparam logic [1:0]  ST_IDLE   = 2'd0;
   localparam logic [1:0]  ST_DATA   = 2'd1;
   localparam logic [1:0]  ST_PARITY = 2'd2;
   localparam logic [1:0]  ST_STOP   = 2'd3;
   localparam logic [7:0]  FILT_LAST = 8'(FILTER_LEN - 1);
   localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

   logic        r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
   logic        r_filt_clk;
   logic [7:0]  r_filt_cnt;
   logic [1:0]  r_state;
   logic [2:0]  r_bitcnt;
   logic [7:0]  r_shreg;
   logic        r_par;
   logic [15:0] r_to_cnt;
   logic        r_ext_flag, r_rel_flag;
   logic [2:0]  r_skip;

   logic        w_fall, w_timeout, w_stop_edge, w_good, w_reply;

   // Synchronisers and the run-length clock filter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_clk_s1   <= 1'b1;
         r_clk_s2   <= 1'b1;
         r_dat_s1   <= 1'b1;
         r_dat_s2   <= 1'b1;
         r_filt_clk <= 1'b1;
         r_filt_cnt <= '0;
      end else begin
         r_clk_s1 <= ps2clk_in;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= ps2data_in;
         r_dat_s2 <= r_dat_s1;
         if (r_clk_s2 == r_filt_clk) begin
            r_filt_cnt <= '0;
         end else if (r_filt_cnt == FILT_LAST) begin
            r_filt_cnt <= '0;
            r_filt_clk <= r_clk_s2;
         end else begin
            r_filt_cnt <= r_filt_cnt + 8'd1;
         end
      end
   end

   assign w_fall      = r_filt_clk && !r_clk_s2 && (r_filt_cnt == FILT_LAST);
   assign w_timeout   = (r_state != ST_IDLE) && !w_fall && (r_to_cnt == TO_LAST);
   assign w_stop_edge = w_fall && (r_state == ST_STOP);
   assign w_good      = r_dat_s2 && (^{r_shreg, r_par});
   assign w_reply     = (r_shreg == 8'hFA) || (r_shreg == 8'hAA) || (r_shreg == 8'hEE) ||
                        (r_shreg == 8'hFE) || (r_shreg == 8'h00) || (r_shreg == 8'hFF);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_bitcnt <= '0;
         r_shreg  <= '0;
         r_par    <= 1'b0;
         r_to_cnt <= '0;
      end else if (w_fall) begin
         r_to_cnt <= '0;
         case (r_state)
            ST_IDLE: begin
               if (!r_dat_s2) begin
                  r_state  <= ST_DATA;
                  r_bitcnt <= '0;
               end
            end
            ST_DATA: begin
               r_shreg  <= {r_dat_s2, r_shreg[7:1]};
               r_bitcnt <= r_bitcnt + 3'd1;
               if (r_bitcnt == 3'd7) begin
                  r_state <= ST_PARITY;
               end
            end
            ST_PARITY: begin
               r_par   <= r_dat_s2;
               r_state <= ST_STOP;
            end
            default: r_state <= ST_IDLE;
         endcase
      end else if (w_timeout) begin
         r_state  <= ST_IDLE;
         r_to_cnt <= '0;
      end else if (r_state != ST_IDLE) begin
         r_to_cnt <= r_to_cnt + 16'd1;
      end
   end

   // Byte layer: prefix tracking, Pause skipping, reply filtering and event output
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_received <= 1'b0;
         scancode      <= '0;
         extended      <= 1'b0;
         released      <= 1'b0;
         parity_error  <= 1'b0;
         frame_timeout <= 1'b0;
         r_ext_flag    <= 1'b0;
         r_rel_flag    <= 1'b0;
         r_skip        <= '0;
      end else begin
         scan_received <= 1'b0;
         parity_error  <= 1'b0;
         frame_timeout <= w_timeout;
         if (w_timeout) begin
            r_ext_flag <= 1'b0;
            r_rel_flag <= 1'b0;
         end else if (w_stop_edge) begin
            if (!w_good) begin
               parity_error <= 1'b1;
               r_ext_flag   <= 1'b0;
               r_rel_flag   <= 1'b0;
            end else if (r_skip != 3'd0) begin
               r_skip <= r_skip - 3'd1;
            end else if (r_shreg == 8'hE1) begin
               r_skip <= 3'd7;
            end else if (r_shreg == 8'hE0) begin
               r_ext_flag <= 1'b1;
            end else if (r_shreg == 8'hF0) begin
               r_rel_flag <= 1'b1;
            end else if (!(w_reply && !r_ext_flag && !r_rel_flag)) begin
               scan_received <= 1'b1;
               scancode      <= r_shreg;
               extended      <= r_ext_flag;
               released      <= r_rel_flag;
               r_ext_flag    <= 1'b0;
               r_rel_flag    <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Randomised PS/2 frame stimulus against a byte-level reference model; a monitor pops expected events.
module tb_ps2_scancode_decoder;

   localparam int FL     = 4;
   localparam int TO     = 100;
   localparam int HALF   = 20;
   localparam int K_SCAN = 0;
   localparam int K_PERR = 1;
   localparam int K_TOUT = 2;

   typedef struct {
      int         kind;
      logic [7:0] code;
      logic       ext;
      logic       rel;
      int         t;
   } exp_t;

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic       ps2clk = 1'b1;
   logic       ps2dat = 1'b1;
   logic       scan_received, extended, released, parity_error, frame_timeout;
   logic [7:0] scancode;

   ps2_scancode_decoder #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .ps2clk_in    (ps2clk),
      .ps2data_in   (ps2dat),
      .scan_received(scan_received),
      .scancode     (scancode),
      .extended     (extended),
      .released     (released),
      .parity_error (parity_error),
      .frame_timeout(frame_timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: byte-level decoding rules
   exp_t       q[$];
   int         m_skip = 0;
   bit         m_ext  = 1'b0;
   bit         m_rel  = 1'b0;
   logic [7:0] last_code = 8'h00;
   logic       last_ext  = 1'b0;
   logic       last_rel  = 1'b0;

   task automatic expect_evt(input int kind, input logic [7:0] c, input logic e, input logic r, input int t);
      exp_t x;
      x.kind = kind;
      x.code = c;
      x.ext  = e;
      x.rel  = r;
      x.t    = t;
      q.push_back(x);
   endtask

   task automatic model_byte(input logic [7:0] b, input bit good, input int t);
      bit is_reply;
      is_reply = (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) ||
                 (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
      if (!good) begin
         expect_evt(K_PERR, 8'h00, 1'b0, 1'b0, t);
         m_ext = 1'b0;
         m_rel = 1'b0;
      end else if (m_skip > 0) begin
         m_skip--;
      end else if (b == 8'hE1) begin
         m_skip = 7;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_rel = 1'b1;
      end else if (!(is_reply && !m_ext && !m_rel)) begin
         expect_evt(K_SCAN, b, m_ext, m_rel, t);
         m_ext = 1'b0;
         m_rel = 1'b0;
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Output appears FL+2 bench cycles after the falling edge is driven (2 sync + FL filter).
   task automatic ps2_fall(input logic v, output int t_fall);
      ps2dat = v;
      wait_cyc(HALF / 2);
      ps2clk = 1'b0;
      t_fall = cyc;
   endtask

   task automatic ps2_rise();
      wait_cyc(HALF);
      ps2clk = 1'b1;
      wait_cyc(HALF / 2);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      logic [10:0] bits;
      int          t;
      bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         ps2_fall(bits[i], t);
         if (i == 10) model_byte(b, !(bad_par || bad_stop), t + FL + 2);
         ps2_rise();
      end
      ps2dat = 1'b1;
   endtask

   task automatic send_partial(input int nbits);
      int t;
      for (int i = 0; i < nbits; i++) begin
         ps2_fall((i == 0) ? 1'b0 : 1'($urandom_range(0, 1)), t);
         if (i == nbits - 1) begin
            expect_evt(K_TOUT, 8'h00, 1'b0, 1'b0, t + FL + 2 + TO);
            m_ext = 1'b0;
            m_rel = 1'b0;
         end
         ps2_rise();
      end
      ps2dat = 1'b1;
      wait_cyc(TO + 20);
   endtask

   // Monitor
   int   mon_kind;
   exp_t mon_e;
   always @(negedge clk) begin
      if (!rst) begin
         if (scan_received || parity_error || frame_timeout) begin
            mon_kind = scan_received ? K_SCAN : (parity_error ? K_PERR : K_TOUT);
            check("strobe_count", int'(scan_received) + int'(parity_error) + int'(frame_timeout), 1);
            if (q.size() == 0) begin
               check("unexpected_event", mon_kind, -1);
            end else begin
               mon_e = q.pop_front();
               check("event_kind", mon_kind, mon_e.kind);
               check("event_cycle", cyc, mon_e.t);
               if (mon_e.kind == K_SCAN) begin
                  check("scancode", int'(scancode), int'(mon_e.code));
                  check("extended", int'(extended), int'(mon_e.ext));
                  check("released", int'(released), int'(mon_e.rel));
                  last_code = mon_e.code;
                  last_ext  = mon_e.ext;
                  last_rel  = mon_e.rel;
               end
            end
         end else begin
            check("output_hold", int'({scancode, extended, released}),
                  int'({last_code, last_ext, last_rel}));
         end
      end
   end

   logic [7:0] replies [6];
   logic [7:0] rb;
   int         r;

   initial begin
      replies = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
      rst = 1'b1;
      wait_cyc(4);
      check("rst_scan_received", int'(scan_received), 0);
      check("rst_scancode", int'(scancode), 0);
      check("rst_extended", int'(extended), 0);
      check("rst_released", int'(released), 0);
      check("rst_parity_error", int'(parity_error), 0);
      check("rst_frame_timeout", int'(frame_timeout), 0);
      rst = 1'b0;
      wait_cyc(10);

      send_frame(8'h1C, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0);
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h75, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'h75, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b1, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h33, 1'b1, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0);
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b1);
      send_frame(8'h1C, 1'b0, 1'b0);
      send_frame(8'hE1, 1'b0, 1'b0);
      send_frame(8'h14, 1'b0, 1'b0);
      send_frame(8'h77, 1'b0, 1'b0);
      send_frame(8'hE1, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h14, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h77, 1'b0, 1'b0);
      send_frame(8'h16, 1'b0, 1'b0);
      send_frame(8'hAA, 1'b0, 1'b0);
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'hAA, 1'b0, 1'b0);

      // Partial frame aborted by timeout; pending F0 must not leak into the next byte
      send_frame(8'hF0, 1'b0, 1'b0);
      send_partial(4);
      send_frame(8'h1C, 1'b0, 1'b0);

      // Short clock glitch with data low must not start a frame
      ps2dat = 1'b0;
      wait_cyc(3);
      ps2clk = 1'b0;
      wait_cyc(2);
      ps2clk = 1'b1;
      wait_cyc(10);
      ps2dat = 1'b1;
      wait_cyc(10);
      send_frame(8'h1C, 1'b0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 15);
         case (r)
            0, 1:    rb = 8'hE0;
            2, 3:    rb = 8'hF0;
            4:       rb = 8'hE1;
            5:       rb = replies[$urandom_range(0, 5)];
            default: rb = 8'($urandom_range(0, 255));
         endcase
         send_frame(rb, ($urandom_range(0, 15) == 0), 1'b0);
      end

      for (int i = 0; i < 2000 && q.size() != 0; i++) wait_cyc(1);
      wait_cyc(50);
      check("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
